fifo_stream_reader: RTL and testbench



---
 rtl/fifo.sv | 66 ++++++
 rtl/fifo_stream_reader.sv | 103 ++++++++++
 tb/tb_fifo_stream_reader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo.sv
// Generic synchronous FIFO, DEPTH x WIDTH, power-of-two depth.
// Latency: rdata_o valid the cycle after a sampled rd_en_i; empty/full update one edge after a push/pop.
// Backpressure: pushes while full and pops while empty are ignored.
module fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] rdata_q;
  logic             do_wr;
  logic             do_rd;

  // Qualify push/pop against the current occupancy and expose the flags.
  always_comb begin
    full_o  = (count_q == (AW + 1)'(DEPTH));
    empty_o = (count_q == '0);
    do_wr   = wr_en_i && !full_o;
    do_rd   = rd_en_i && !empty_o;
    rdata_o = rdata_q;
  end

  // Storage array; no reset needed since the pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers, occupancy count and the registered read port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_q  <= mem[rd_ptr_q];
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO and presents its words as a valid/ready stream.
// Latency: 2 cycles from fifo_rd_en_o high to m_valid_o high; 1 word/clk sustained.
// Backpressure: m_ready_i low holds m_data_o; pops are throttled so the 2-entry buffer never overflows.
module fifo_stream_reader #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  output logic             fifo_rd_en_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic [CNT_W-1:0] pop_count_o
);
  // Buffer occupancy encoding.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic             inflight_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] tail_q;
  logic [WIDTH-1:0] tail_d;
  logic [CNT_W-1:0] pop_cnt_q;
  logic             pop;
  logic [2:0]       level;

  // State, capture flag, buffer entries and pop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      pop_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en_o;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pop_cnt_q  <= pop_cnt_q + CNT_W'(fifo_rd_en_o);
    end
  end

  // Next occupancy: a word in flight is captured this edge, an accepted head leaves.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (inflight_q) begin
          state_d = ONE;
          head_d  = fifo_rdata_i;
        end
      end
      ONE: begin
        if (inflight_q && !pop) begin
          state_d = TWO;
          tail_d  = fifo_rdata_i;
        end else if (inflight_q && pop) begin
          head_d  = fifo_rdata_i;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop && inflight_q) begin
          head_d  = tail_q;
          tail_d  = fifo_rdata_i;
        end else if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Stream outputs and pop request; the pop is allowed only if the word it
  // fetches is guaranteed a free slot when it lands, counting this cycle's accept.
  always_comb begin
    m_valid_o    = (state_q != EMPTY);
    m_data_o     = head_q;
    pop          = m_valid_o && m_ready_i;
    level        = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en_o = !fifo_empty_i && (level <= 3'd1);
    pop_count_o  = pop_cnt_q;
  end

  // A capture into a full buffer without an accept would lose a word.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(state_q == TWO && inflight_q && !pop));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: generic FIFO feeding fifo_stream_reader, checked every cycle against a
// word-count model (words issued / in flight / delivered) plus literal expectations.
// Stimulus is directed; all inputs are driven 1 time unit after the rising edge.
module tb_fifo_stream_reader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wdata = 4'h0;
  logic       full;
  logic       empty;
  logic       rd_en;
  logic [3:0] rdata;
  logic       m_valid;
  logic [3:0] m_data;
  logic       m_ready = 1'b0;
  logic [7:0] pop_count;

  always #5 clk = ~clk;

  fifo #(.DEPTH(16), .WIDTH(4)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .wr_en_i (wr_en),
    .wdata_i (wdata),
    .full_o  (full),
    .rd_en_i (rd_en),
    .rdata_o (rdata),
    .empty_o (empty)
  );

  fifo_stream_reader #(.WIDTH(4), .CNT_W(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .fifo_empty_i (empty),
    .fifo_rdata_i (rdata),
    .fifo_rd_en_o (rd_en),
    .m_valid_o    (m_valid),
    .m_data_o     (m_data),
    .m_ready_i    (m_ready),
    .pop_count_o  (pop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Words accepted by the FIFO since the last reset (stimulus-owned).
  logic [3:0] wq[$];
  int phase = 0;

  // Model state (compare-process owned).
  int   issued    = 0;
  int   delivered = 0;
  int   cyc       = 0;
  bit   inflight_m = 1'b0;
  bit   prev_stall = 1'b0;
  logic [3:0] prev_data = 4'h0;
  int   first_rd[8]  = '{default: -1};
  int   first_vld[8] = '{default: -1};
  int   first_dlv[8] = '{default: -1};
  int   last_dlv[8]  = '{default: -1};
  int   dlv_cnt[8]   = '{default: 0};
  int   vld_cnt[8]   = '{default: 0};
  logic [3:0] last_dat[8] = '{default: 4'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the count model.
  always @(negedge clk) begin
    int buffered;
    bit exp_vld;
    bit exp_pop;
    bit exp_rd;
    if (!rst_n) begin
      issued     = 0;
      delivered  = 0;
      inflight_m = 1'b0;
      prev_stall = 1'b0;
      check("rst_m_valid", {31'b0, m_valid}, 32'd0);
      check("rst_rd_en", {31'b0, rd_en}, 32'd0);
      check("rst_pop_count", {24'b0, pop_count}, 32'd0);
    end else begin
      buffered = issued - int'(inflight_m) - delivered;
      exp_vld  = (buffered > 0);
      exp_pop  = exp_vld && m_ready;
      exp_rd   = !empty && ((buffered + int'(inflight_m) - int'(exp_pop)) <= 1);
      check("m_valid", {31'b0, m_valid}, {31'b0, exp_vld});
      if (exp_vld) begin
        if (delivered < wq.size()) begin
          check("m_data", {28'b0, m_data}, {28'b0, wq[delivered]});
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL m_data_extra: valid word %0d but only %0d written", delivered, wq.size());
        end
      end
      check("rd_en", {31'b0, rd_en}, {31'b0, exp_rd});
      check("rd_en_while_empty", {31'b0, rd_en & empty}, 32'd0);
      check("pop_count", {24'b0, pop_count}, 32'(issued % 256));
      if (prev_stall) begin
        check("stall_valid", {31'b0, m_valid}, 32'd1);
        check("stall_data", {28'b0, m_data}, {28'b0, prev_data});
      end
      if (exp_rd && first_rd[phase] < 0) first_rd[phase] = cyc;
      if (exp_vld) begin
        if (first_vld[phase] < 0) first_vld[phase] = cyc;
        vld_cnt[phase]++;
      end
      if (exp_pop) begin
        if (first_dlv[phase] < 0) first_dlv[phase] = cyc;
        last_dlv[phase] = cyc;
        dlv_cnt[phase]++;
        last_dat[phase] = m_data;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (exp_pop) delivered++;
      if (exp_rd) issued++;
      inflight_m = exp_rd;
    end
    cyc++;
  end

  task automatic write_words(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b1;
      wdata = 4'(start + i);
      if (!full) wq.push_back(4'(start + i));
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (delivered < wq.size() && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("drain_done", {31'b0, (delivered >= wq.size())}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with FIFO empty; compare process checks the reset values.
    #32;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_rd_en", {31'b0, rd_en}, 32'd0);
    check("idle_pop_count", {24'b0, pop_count}, 32'd0);

    // Phase 1: 16 words streamed with the consumer always ready.
    phase = 1;
    m_ready = 1'b1;
    write_words(16, 1);
    wait_drain(100);
    check("p1_pop_count", {24'b0, pop_count}, 32'd16);
    check("p1_latency", 32'(first_vld[1] - first_rd[1]), 32'd2);
    check("p1_dlv_cnt", 32'(dlv_cnt[1]), 32'd16);
    check("p1_no_gaps", 32'(last_dlv[1] - first_dlv[1]), 32'd15);
    check("p1_last_word", {28'b0, last_dat[1]}, 32'h0);

    // Phase 2: consumer stalled, 5 words queued; only two may be popped.
    @(posedge clk); #1;
    phase = 2;
    m_ready = 1'b0;
    write_words(5, 1);
    repeat (6) @(posedge clk);
    #1;
    check("p2_pop_count_stall", {24'b0, pop_count}, 32'd18);
    check("p2_valid", {31'b0, m_valid}, 32'd1);
    check("p2_head", {28'b0, m_data}, 32'h1);
    check("p2_rd_en_full", {31'b0, rd_en}, 32'd0);
    m_ready = 1'b1;
    wait_drain(100);
    check("p2_dlv_cnt", 32'(dlv_cnt[2]), 32'd5);
    check("p2_no_gaps", 32'(last_dlv[2] - first_dlv[2]), 32'd4);
    check("p2_pop_count", {24'b0, pop_count}, 32'd21);

    // Phase 3: 8 words preloaded, ready toggling every cycle.
    @(posedge clk); #1;
    phase = 3;
    m_ready = 1'b0;
    write_words(8, 8);
    for (int k = 0; k < 100 && delivered < wq.size(); k++) begin
      @(posedge clk); #1;
      m_ready = !m_ready;
    end
    m_ready = 1'b1;
    wait_drain(20);
    check("p3_dlv_cnt", 32'(dlv_cnt[3]), 32'd8);
    check("p3_last_word", {28'b0, last_dat[3]}, 32'hF);
    check("p3_pop_count", {24'b0, pop_count}, 32'd29);

    // Phase 4: single word while idle.
    @(posedge clk); #1;
    phase = 4;
    write_words(1, 10);
    wait_drain(20);
    repeat (3) @(posedge clk);
    #1;
    check("p4_valid_beats", 32'(vld_cnt[4]), 32'd1);
    check("p4_dlv_word", {28'b0, last_dat[4]}, 32'hA);
    check("p4_idle_valid", {31'b0, m_valid}, 32'd0);
    check("p4_idle_rd_en", {31'b0, rd_en}, 32'd0);
    check("p4_pop_count", {24'b0, pop_count}, 32'd30);

    // Phase 5: reset while the buffer is full and the FIFO still holds words.
    phase = 5;
    m_ready = 1'b0;
    write_words(8, 3);
    repeat (4) @(posedge clk);
    #1;
    check("p5_pre_valid", {31'b0, m_valid}, 32'd1);
    check("p5_pre_pop_count", {24'b0, pop_count}, 32'd32);
    #2;
    rst_n = 1'b0;
    wq.delete();
    #1;
    check("p5_async_valid", {31'b0, m_valid}, 32'd0);
    check("p5_async_data", {28'b0, m_data}, 32'd0);
    check("p5_async_rd_en", {31'b0, rd_en}, 32'd0);
    check("p5_async_pop_count", {24'b0, pop_count}, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Phase 6: clean restart with new words.
    @(posedge clk); #1;
    phase = 6;
    m_ready = 1'b1;
    write_words(3, 5);
    wait_drain(50);
    check("p6_dlv_cnt", 32'(dlv_cnt[6]), 32'd3);
    check("p6_last_word", {28'b0, last_dat[6]}, 32'h7);
    check("p6_pop_count", {24'b0, pop_count}, 32'd3);

    // Phase 7: long stream so the pop counter wraps.
    phase = 7;
    write_words(260, 0);
    wait_drain(100);
    check("p7_dlv_cnt", 32'(dlv_cnt[7]), 32'd260);
    check("p7_pop_count_wrap", {24'b0, pop_count}, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
